// File: rtl/rib_bus_arbiter_if.sv
// Bundles the NM-master request side and the single RIB slave side of the arbiter.
// The master modport is the arbiter's view; the slave modport is the environment's view.
interface rib_bus_arbiter_if #(
  parameter int NM = 3,
  parameter int AW = 32,
  parameter int DW = 32
);
  logic [NM-1:0]    m_req_i;
  logic [NM-1:0]    m_we_i;
  logic [NM*AW-1:0] m_addr_i;
  logic [NM*DW-1:0] m_wdata_i;
  logic [NM-1:0]    m_ack_o;
  logic [NM-1:0]    m_err_o;
  logic [DW-1:0]    m_rdata_o;
  logic [NM-1:0]    m_hold_o;
  logic             s_req_o;
  logic             s_we_o;
  logic [AW-1:0]    s_addr_o;
  logic [DW-1:0]    s_wdata_o;
  logic             s_ack_i;
  logic [DW-1:0]    s_rdata_i;

  modport master (
    input  m_req_i, m_we_i, m_addr_i, m_wdata_i, s_ack_i, s_rdata_i,
    output m_ack_o, m_err_o, m_rdata_o, m_hold_o, s_req_o, s_we_o, s_addr_o, s_wdata_o
  );

  modport slave (
    output m_req_i, m_we_i, m_addr_i, m_wdata_i, s_ack_i, s_rdata_i,
    input  m_ack_o, m_err_o, m_rdata_o, m_hold_o, s_req_o, s_we_o, s_addr_o, s_wdata_o
  );
endinterface

// File: rtl/rib_bus_arbiter.sv
// Round-robin arbiter sharing one RIB slave among NM masters; grant locked per transaction.
// One idle cycle between transactions; ack/err are routed combinationally from the slave or timeout.
module rib_bus_arbiter #(
  parameter int NM    = 3,
  parameter int AW    = 32,
  parameter int DW    = 32,
  parameter int TMO_W = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  rib_bus_arbiter_if.master  bus
);
  localparam int PW = (NM > 1) ? $clog2(NM) : 1;
  localparam logic [PW:0]       NM_W     = (PW+1)'(NM);
  localparam logic [PW-1:0]     LAST_IDX = PW'(NM - 1);
  localparam logic [NM-1:0]     ONE_HOT0 = NM'(1);
  localparam logic [TMO_W-1:0]  TMO_LAST = {TMO_W{1'b1}} - TMO_W'(1);

  typedef enum logic {IDLE, BUSY} state_t;

  state_t           state;
  logic [NM-1:0]    gnt;
  logic [PW-1:0]    gnt_idx;
  logic [PW-1:0]    rr_ptr;
  logic [TMO_W-1:0] tmo_cnt;

  logic             busy;
  logic             tmo_fire;
  logic             done;
  logic             pick_vld;
  logic [PW-1:0]    pick_idx;
  logic [PW:0]      cand;
  logic [PW-1:0]    next_ptr;
  logic             mux_we;
  logic [AW-1:0]    mux_addr;
  logic [DW-1:0]    mux_wdata;

  assign busy     = (state == BUSY);
  // Fires on the cycle the wait count would reach all-ones, so the counter never wraps.
  assign tmo_fire = busy & ~bus.s_ack_i & (tmo_cnt == TMO_LAST);
  assign done     = busy & (bus.s_ack_i | tmo_fire);
  assign next_ptr = (gnt_idx == LAST_IDX) ? '0 : gnt_idx + 1'b1;

  always_comb begin
    pick_vld = 1'b0;
    pick_idx = '0;
    cand     = '0;
    for (int off = 0; off < NM; off++) begin
      cand = {1'b0, rr_ptr} + (PW+1)'(off);
      if (cand >= NM_W) cand = cand - NM_W;
      if (!pick_vld && bus.m_req_i[cand[PW-1:0]]) begin
        pick_vld = 1'b1;
        pick_idx = cand[PW-1:0];
      end
    end
  end

  // gnt is cleared outside BUSY, so the slave-side mux reads zero when idle.
  always_comb begin
    mux_we    = 1'b0;
    mux_addr  = '0;
    mux_wdata = '0;
    for (int k = 0; k < NM; k++) begin
      if (gnt[k]) begin
        mux_we    = mux_we    | bus.m_we_i[k];
        mux_addr  = mux_addr  | bus.m_addr_i[k*AW +: AW];
        mux_wdata = mux_wdata | bus.m_wdata_i[k*DW +: DW];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      gnt     <= '0;
      gnt_idx <= '0;
      rr_ptr  <= '0;
      tmo_cnt <= '0;
    end else begin
      case (state)
        IDLE: begin
          tmo_cnt <= '0;
          if (pick_vld) begin
            gnt     <= ONE_HOT0 << pick_idx;
            gnt_idx <= pick_idx;
            state   <= BUSY;
          end
        end
        BUSY: begin
          if (done) begin
            gnt     <= '0;
            rr_ptr  <= next_ptr;
            tmo_cnt <= '0;
            state   <= IDLE;
          end else begin
            tmo_cnt <= tmo_cnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.s_req_o   = busy;
  assign bus.s_we_o    = mux_we;
  assign bus.s_addr_o  = mux_addr;
  assign bus.s_wdata_o = mux_wdata;
  assign bus.m_ack_o   = done ? gnt : '0;
  assign bus.m_err_o   = tmo_fire ? gnt : '0;
  assign bus.m_rdata_o = (busy & bus.s_ack_i & ~mux_we) ? bus.s_rdata_i : '0;
  assign bus.m_hold_o  = bus.m_req_i & ~bus.m_ack_o;
endmodule

// File: tb/tb_rib_bus_arbiter.sv
// Directed bench for rib_bus_arbiter: expected acks are queued by the stimulus and
// popped by an independent monitor; a small slave model answers after a set wait.
module tb_rib_bus_arbiter;
  localparam int NM = 3;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int TMO_W = 4;

  typedef struct packed {
    logic [NM-1:0] ack;
    logic [NM-1:0] err;
    logic [DW-1:0] rdata;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   errors = 0;
  exp_t exp_q[$];

  int          slave_wait = 0;
  logic [31:0] slave_rdata = 32'h0;
  bit          force_ack = 1'b0;

  rib_bus_arbiter_if #(.NM(NM), .AW(AW), .DW(DW)) bus ();

  rib_bus_arbiter #(.NM(NM), .AW(AW), .DW(DW), .TMO_W(TMO_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  task automatic push(input logic [NM-1:0] ack, input logic [NM-1:0] err, input logic [DW-1:0] rd);
    exp_t e;
    e.ack = ack; e.err = err; e.rdata = rd;
    exp_q.push_back(e);
  endtask

  task automatic wait_ack(input int max, output int n);
    bit got = 1'b0;
    n = 0;
    for (int c = 0; c < max; c++) begin
      @(negedge clk);
      n++;
      if (|bus.m_ack_o) begin
        got = 1'b1;
        break;
      end
    end
    if (!got) begin
      checks++;
      errors++;
      $display("FAIL ack_wait actual=none required=ack within %0d cycles", max);
    end
  endtask

  task automatic set_req(input logic [NM-1:0] req);
    @(posedge clk);
    #1;
    bus.m_req_i = req;
  endtask

  // Scoreboard monitor
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst_n && (|bus.m_ack_o)) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL sb_unexpected actual=ack %b err %b required=no ack", bus.m_ack_o, bus.m_err_o);
        end else begin
          e = exp_q.pop_front();
          chk("sb_ack_err_rdata", 64'({bus.m_ack_o, bus.m_err_o, bus.m_rdata_o}),
              64'({e.ack, e.err, e.rdata}));
        end
      end
    end
  end

  // Slave model: acks on BUSY cycle number slave_wait (0 = same cycle), never if negative
  initial begin
    int  busy_cnt = 0;
    bit  prev_req = 1'b0;
    bus.s_ack_i   = 1'b0;
    bus.s_rdata_i = '0;
    forever begin
      @(posedge clk);
      #1;
      bus.s_rdata_i = slave_rdata;
      if (rst_n && bus.s_req_o) begin
        busy_cnt = prev_req ? busy_cnt + 1 : 0;
        bus.s_ack_i = force_ack || (slave_wait >= 0 && busy_cnt == slave_wait);
      end else begin
        busy_cnt = 0;
        bus.s_ack_i = force_ack;
      end
      prev_req = rst_n && bus.s_req_o;
    end
  end

  initial begin
    int n;
    int cnt_we;
    int pulses;
    bit hold_ok;
    bus.m_req_i   = '0;
    bus.m_we_i    = '0;
    bus.m_addr_i  = '0;
    bus.m_wdata_i = '0;

    // Reset state
    #12;
    chk("rst_s_req", 64'(bus.s_req_o), 64'h0);
    chk("rst_ack", 64'(bus.m_ack_o), 64'h0);
    chk("rst_err", 64'(bus.m_err_o), 64'h0);
    chk("rst_rdata", 64'(bus.m_rdata_o), 64'h0);
    chk("rst_hold", 64'(bus.m_hold_o), 64'h0);
    @(posedge clk); #1 rst_n = 1'b1;

    // T1: single m0 read, zero-wait slave
    slave_wait = 0;
    slave_rdata = 32'hDEADBEEF;
    bus.m_addr_i[0*AW +: AW] = 32'h0000_0100;
    push(3'b001, 3'b000, 32'hDEADBEEF);
    set_req(3'b001);
    @(negedge clk);
    chk("t1_no_req_first_cycle", 64'(bus.s_req_o), 64'h0);
    chk("t1_hold_before_ack", 64'(bus.m_hold_o), 64'h1);
    wait_ack(10, n);
    chk("t1_latency", 64'(n), 64'd1);
    chk("t1_s_addr", 64'(bus.s_addr_o), 64'h100);
    chk("t1_hold_at_ack", 64'(bus.m_hold_o), 64'h0);
    set_req(3'b000);

    // T2: after reset, all masters request continuously
    @(posedge clk); #1 rst_n = 1'b0;
    @(posedge clk); #1 rst_n = 1'b1;
    slave_rdata = 32'h0000_1234;
    for (int i = 0; i < 6; i++) push(3'b001 << (i % 3), 3'b000, 32'h1234);
    set_req(3'b111);
    for (int i = 0; i < 6; i++) begin
      wait_ack(10, n);
      if (i > 0) chk("t2_ack_spacing", 64'(n), 64'd2);
    end
    set_req(3'b000);

    // T3: m1 write, slave acks after 3 wait cycles
    slave_wait = 3;
    slave_rdata = 32'hFFFF_FFFF;
    bus.m_we_i = 3'b010;
    bus.m_addr_i[1*AW +: AW]  = 32'h1000_0004;
    bus.m_wdata_i[1*DW +: DW] = 32'h0000_0055;
    push(3'b010, 3'b000, 32'h0);
    set_req(3'b010);
    cnt_we = 0;
    hold_ok = 1'b1;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (bus.s_req_o && bus.s_we_o && bus.s_addr_o == 32'h1000_0004 && bus.s_wdata_o == 32'h55)
        cnt_we++;
      if (bus.m_ack_o[1]) break;
      if (!bus.m_hold_o[1]) hold_ok = 1'b0;
    end
    chk("t3_we_cycles", 64'(cnt_we), 64'd4);
    chk("t3_hold_until_ack", 64'(hold_ok), 64'h1);
    chk("t3_hold_at_ack", 64'(bus.m_hold_o[1]), 64'h0);
    set_req(3'b000);
    bus.m_we_i = '0;

    // T4: slave never acks; m0 times out, then m1 is granted
    slave_wait = -1;
    slave_rdata = 32'h0000_ABCD;
    push(3'b001, 3'b001, 32'h0);
    push(3'b010, 3'b000, 32'hABCD);
    set_req(3'b011);
    wait_ack(40, n);
    chk("t4_timeout_cycles", 64'(n), 64'd16);
    slave_wait = 0;
    set_req(3'b010);
    wait_ack(10, n);
    chk("t4_next_grant_latency", 64'(n - 1), 64'd1);
    set_req(3'b000);

    // T5: reset during a BUSY wait
    slave_wait = -1;
    set_req(3'b100);
    repeat (4) @(negedge clk);
    chk("t5_busy_before_reset", 64'(bus.s_req_o), 64'h1);
    #1 rst_n = 1'b0;
    #1;
    chk("t5_s_req_in_reset", 64'(bus.s_req_o), 64'h0);
    chk("t5_ack_in_reset", 64'(bus.m_ack_o), 64'h0);
    bus.m_req_i = '0;
    @(posedge clk); #1 rst_n = 1'b1;
    slave_wait = 0;
    push(3'b001, 3'b000, 32'hABCD);
    set_req(3'b111);
    wait_ack(10, n);
    set_req(3'b000);

    // s_ack_i while IDLE must not produce an ack
    force_ack = 1'b1;
    pulses = 0;
    repeat (3) begin
      @(negedge clk);
      if (|bus.m_ack_o) pulses++;
    end
    chk("idle_ack_ignored", 64'(pulses), 64'd0);
    force_ack = 1'b0;

    // T6: m2 drops its request while BUSY; ack still delivered once
    slave_wait = 2;
    slave_rdata = 32'h0000_0F0F;
    push(3'b100, 3'b000, 32'h0F0F);
    set_req(3'b100);
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (bus.s_req_o) break;
    end
    set_req(3'b000);
    pulses = 0;
    repeat (8) begin
      @(negedge clk);
      if (bus.m_ack_o[2]) pulses++;
    end
    chk("t6_single_ack", 64'(pulses), 64'd1);
    slave_wait = 0;
    push(3'b001, 3'b000, 32'h0F0F);
    set_req(3'b011);
    wait_ack(10, n);
    set_req(3'b000);

    repeat (5) @(negedge clk);
    chk("sb_drained", 64'(exp_q.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "simulation time limit");
  end
endmodule
